// File: rtl/vdp_port.sv
// VDP CPU port: control-word decoder, VRAM pointer with read-ahead buffer,
// registers, CRAM path, status flags and interrupt. Macro LINE_INT_EN adds the line-counter IRQ.
module vdp_port #(
    parameter int VRAM_LAT = 1,
    parameter int NUM_REGS = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_wr,
    input  logic                  io_rd,
    input  logic                  port_ctrl,
    input  logic [7:0]            cpu_din,
    output logic [7:0]            cpu_dout,
    output logic [13:0]           vram_addr,
    output logic                  vram_we,
    output logic [7:0]            vram_wdata,
    output logic                  vram_re,
    input  logic [7:0]            vram_rdata,
    output logic                  cram_we,
    output logic [4:0]            cram_addr,
    output logic [7:0]            cram_wdata,
    output logic [8*NUM_REGS-1:0] regs,
    input  logic                  frame_int,
    input  logic                  spr_coll,
    input  logic                  spr_ovf,
    input  logic [4:0]            spr5,
    input  logic                  line_tick,
    input  logic                  active_line,
    output logic                  n_int
);

    localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

    logic [13:0] addr_q, addr_d;
    logic [1:0]  code_q, code_d;
    logic        latch_q, latch_d;
    logic [7:0]  low_q, low_d;
    logic [7:0]  buf_q, buf_d;
    logic [7:0]  regs_q [NUM_REGS];
    logic [7:0]  regs_d [NUM_REGS];
    logic [13:0] vram_addr_q, vram_addr_d;
    logic        vram_we_q, vram_we_d;
    logic [7:0]  vram_wdata_q, vram_wdata_d;
    logic        vram_re_q, vram_re_d;
    logic        cram_we_q, cram_we_d;
    logic [4:0]  cram_addr_q, cram_addr_d;
    logic [7:0]  cram_wdata_q, cram_wdata_d;
    logic        frame_q, frame_d;
    logic        coll_q, coll_d;
    logic        line_pend_q, line_pend_d;
    logic        clr_q, clr_d;
    logic        n_int_q, n_int_d;
    logic [VRAM_LAT-1:0] valid_q, valid_d;

`ifdef LINE_INT_EN
    // Smaller register files reuse the top register as the reload value.
    localparam int R10_IDX = (NUM_REGS > 10) ? 10 : NUM_REGS - 1;
    logic [7:0] line_cnt_q, line_cnt_d;
`else
    logic unused_line;
    assign unused_line = line_tick ^ active_line;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            assign regs[gi*8 +: 8] = regs_q[gi];
        end
        // One valid bit per outstanding prefetch cycle; the top bit marks rdata valid.
        for (gi = 0; gi < VRAM_LAT; gi++) begin : g_valid
            if (gi == 0) begin : g_first
                assign valid_d[gi] = vram_re_q;
            end else begin : g_rest
                assign valid_d[gi] = valid_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        cpu_dout = 8'h00;
        if (io_rd) begin
            if (port_ctrl)
                cpu_dout = {frame_q, spr_ovf, coll_q, spr_ovf ? spr5 : 5'h1F};
            else
                cpu_dout = buf_q;
        end
    end

    always_comb begin
        addr_d       = addr_q;
        code_d       = code_q;
        latch_d      = latch_q;
        low_d        = low_q;
        buf_d        = buf_q;
        regs_d       = regs_q;
        vram_addr_d  = vram_addr_q;
        vram_we_d    = 1'b0;
        vram_wdata_d = vram_wdata_q;
        vram_re_d    = 1'b0;
        cram_we_d    = 1'b0;
        cram_addr_d  = cram_addr_q;
        cram_wdata_d = cram_wdata_q;
        frame_d      = frame_q;
        coll_d       = coll_q;
        line_pend_d  = line_pend_q;
        clr_d        = 1'b0;
`ifdef LINE_INT_EN
        line_cnt_d   = line_cnt_q;
`endif

        if (valid_q[VRAM_LAT-1])
            buf_d = vram_rdata;

        // Status clear lands one cycle after the read; a same-cycle set wins.
        if (clr_q) begin
            frame_d     = 1'b0;
            coll_d      = 1'b0;
            line_pend_d = 1'b0;
            latch_d     = 1'b0;
        end
        if (frame_int)
            frame_d = 1'b1;
        if (spr_coll)
            coll_d = 1'b1;

`ifdef LINE_INT_EN
        if (line_tick) begin
            if (active_line) begin
                if (line_cnt_q == 8'h00) begin
                    line_cnt_d  = regs_q[R10_IDX];
                    line_pend_d = 1'b1;
                end else begin
                    line_cnt_d = line_cnt_q - 8'd1;
                end
            end else begin
                line_cnt_d = regs_q[R10_IDX];
            end
        end
`endif

        if (io_wr && port_ctrl) begin
            if (!latch_q) begin
                low_d   = cpu_din;
                latch_d = 1'b1;
            end else begin
                latch_d = 1'b0;
                code_d  = cpu_din[7:6];
                addr_d  = {cpu_din[5:0], low_q};
                if (cpu_din[7:6] == 2'd0) begin
                    vram_re_d   = 1'b1;
                    vram_addr_d = {cpu_din[5:0], low_q};
                    addr_d      = {cpu_din[5:0], low_q} + 14'd1;
                end else if (cpu_din[7:6] == 2'd2) begin
                    if ({1'b0, cpu_din[3:0]} < NUM_REGS_W)
                        regs_d[cpu_din[3:0]] = low_q;
                end
            end
        end else if (io_wr) begin
            latch_d = 1'b0;
            buf_d   = cpu_din;
            addr_d  = addr_q + 14'd1;
            if (code_q == 2'd3) begin
                cram_we_d    = 1'b1;
                cram_addr_d  = addr_q[4:0];
                cram_wdata_d = cpu_din;
            end else begin
                vram_we_d    = 1'b1;
                vram_addr_d  = addr_q;
                vram_wdata_d = cpu_din;
            end
        end else if (io_rd && !port_ctrl) begin
            latch_d     = 1'b0;
            vram_re_d   = 1'b1;
            vram_addr_d = addr_q;
            addr_d      = addr_q + 14'd1;
        end else if (io_rd) begin
            clr_d = 1'b1;
        end

`ifndef LINE_INT_EN
        line_pend_d = 1'b0;
`endif
        n_int_d = ~((frame_d & regs_d[1][5]) | (line_pend_d & regs_d[0][4]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q       <= 14'h0000;
            code_q       <= 2'd0;
            latch_q      <= 1'b0;
            low_q        <= 8'h00;
            buf_q        <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= 8'h00;
            vram_addr_q  <= 14'h0000;
            vram_we_q    <= 1'b0;
            vram_wdata_q <= 8'h00;
            vram_re_q    <= 1'b0;
            cram_we_q    <= 1'b0;
            cram_addr_q  <= 5'd0;
            cram_wdata_q <= 8'h00;
            frame_q      <= 1'b0;
            coll_q       <= 1'b0;
            line_pend_q  <= 1'b0;
            clr_q        <= 1'b0;
            n_int_q      <= 1'b1;
            valid_q      <= '0;
`ifdef LINE_INT_EN
            line_cnt_q   <= 8'hFF;
`endif
        end else begin
            addr_q       <= addr_d;
            code_q       <= code_d;
            latch_q      <= latch_d;
            low_q        <= low_d;
            buf_q        <= buf_d;
            regs_q       <= regs_d;
            vram_addr_q  <= vram_addr_d;
            vram_we_q    <= vram_we_d;
            vram_wdata_q <= vram_wdata_d;
            vram_re_q    <= vram_re_d;
            cram_we_q    <= cram_we_d;
            cram_addr_q  <= cram_addr_d;
            cram_wdata_q <= cram_wdata_d;
            frame_q      <= frame_d;
            coll_q       <= coll_d;
            line_pend_q  <= line_pend_d;
            clr_q        <= clr_d;
            n_int_q      <= n_int_d;
            valid_q      <= valid_d;
`ifdef LINE_INT_EN
            line_cnt_q   <= line_cnt_d;
`endif
        end
    end

    assign vram_addr  = vram_addr_q;
    assign vram_we    = vram_we_q;
    assign vram_wdata = vram_wdata_q;
    assign vram_re    = vram_re_q;
    assign cram_we    = cram_we_q;
    assign cram_addr  = cram_addr_q;
    assign cram_wdata = cram_wdata_q;
    assign n_int      = n_int_q;

endmodule

// File: tb/tb_vdp_port.sv
// Bench for vdp_port: scoreboarded VRAM/CRAM pulses, read data from a 1- and 3-cycle latency instance.
module tb_vdp_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_wr, io_rd, port_ctrl;
    logic [7:0]  cpu_din;
    logic        frame_int, spr_coll, spr_ovf, line_tick, active_line;
    logic [4:0]  spr5;

    logic [7:0]  cpu_dout, vram_wdata, vram_rdata, cram_wdata;
    logic [13:0] vram_addr;
    logic        vram_we, vram_re, cram_we, n_int;
    logic [4:0]  cram_addr;
    logic [87:0] regs;

    logic [7:0]  cpu_dout3, vram_wdata3, vram_rdata3, cram_wdata3;
    logic [13:0] vram_addr3;
    logic        vram_we3, vram_re3, cram_we3, n_int3;
    logic [4:0]  cram_addr3;
    logic [87:0] regs3;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [1:0]  kind;   // 0 vram write, 1 vram prefetch, 2 cram write
        logic [13:0] addr;
        logic [7:0]  data;
    } ev_t;
    ev_t exp_q[$];
    logic [87:0] exp_regs;

    always #5 clk = ~clk;

    vdp_port #(.VRAM_LAT(1), .NUM_REGS(11)) dut (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .port_ctrl(port_ctrl),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .vram_addr(vram_addr), .vram_we(vram_we),
        .vram_wdata(vram_wdata), .vram_re(vram_re), .vram_rdata(vram_rdata),
        .cram_we(cram_we), .cram_addr(cram_addr), .cram_wdata(cram_wdata), .regs(regs),
        .frame_int(frame_int), .spr_coll(spr_coll), .spr_ovf(spr_ovf), .spr5(spr5),
        .line_tick(line_tick), .active_line(active_line), .n_int(n_int)
    );

    vdp_port #(.VRAM_LAT(3), .NUM_REGS(11)) dut3 (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .port_ctrl(port_ctrl),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout3), .vram_addr(vram_addr3), .vram_we(vram_we3),
        .vram_wdata(vram_wdata3), .vram_re(vram_re3), .vram_rdata(vram_rdata3),
        .cram_we(cram_we3), .cram_addr(cram_addr3), .cram_wdata(cram_wdata3), .regs(regs3),
        .frame_int(frame_int), .spr_coll(spr_coll), .spr_ovf(spr_ovf), .spr5(spr5),
        .line_tick(line_tick), .active_line(active_line), .n_int(n_int3)
    );

    // VRAM model: written by the 1-cycle instance, read with each instance's latency.
    logic [7:0]  mem [0:16383];
    logic [13:0] p1;
    logic [13:0] p3 [3];
    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        p1    <= vram_addr;
        p3[0] <= vram_addr3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign vram_rdata  = mem[p1];
    assign vram_rdata3 = mem[p3[2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_pop(input logic [1:0] kind, input logic [13:0] addr, input logic [7:0] data);
        ev_t e;
        $display("txn kind=%0d addr=%04h data=%02h", kind, addr, data);
        if (exp_q.size() == 0) begin
            chk("sb_unexpected_kind", 32'(kind), 32'd3);
        end else begin
            e = exp_q.pop_front();
            chk("sb_kind", 32'(kind), 32'(e.kind));
            chk("sb_addr", 32'(addr), 32'(e.addr));
            if (kind != 2'd1) chk("sb_data", 32'(data), 32'(e.data));
        end
    endtask

    always @(negedge clk) begin
        if (vram_we) sb_pop(2'd0, vram_addr, vram_wdata);
        if (vram_re) sb_pop(2'd1, vram_addr, 8'h00);
        if (cram_we) sb_pop(2'd2, {9'd0, cram_addr}, cram_wdata);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] k, input logic [13:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic ctrl, input logic [7:0] d);
        io_wr = 1'b1; port_ctrl = ctrl; cpu_din = d;
        cyc(1);
        io_wr = 1'b0;
        cyc(5);
    endtask

    task automatic rd(input logic ctrl, output logic [7:0] d, output logic [7:0] d3);
        io_rd = 1'b1; port_ctrl = ctrl;
        #1;
        d  = cpu_dout;
        d3 = cpu_dout3;
        @(posedge clk);
        #1;
        io_rd = 1'b0;
        cyc(5);
    endtask

    task automatic tick(input logic act);
        line_tick = 1'b1; active_line = act;
        cyc(1);
        line_tick = 1'b0;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, d3;
        reset = 1'b1; io_wr = 0; io_rd = 0; port_ctrl = 0; cpu_din = 0;
        frame_int = 0; spr_coll = 0; spr_ovf = 0; spr5 = 0; line_tick = 0; active_line = 0;
        exp_regs = '0;
        cyc(3);
        chk("rst_n_int", 32'(n_int), 1);
        chk("rst_regs", 32'(regs[31:0]), 0);
        chk("rst_cpu_dout", 32'(cpu_dout), 0);
        chk("rst_vram_addr", 32'(vram_addr), 0);
        chk("rst_pulses", {29'd0, vram_we, vram_re, cram_we}, 0);
        reset = 1'b0;
        cyc(2);

        // Fill VRAM[0..1] through the data port, then read it back via prefetch.
        wr(1, 8'h00); wr(1, 8'h40);
        push(0, 14'h0000, 8'h11); wr(0, 8'h11);
        push(0, 14'h0001, 8'h22); wr(0, 8'h22);
        wr(1, 8'h00); push(1, 14'h0000, 8'h00); wr(1, 8'h00);
        push(1, 14'h0001, 8'h00); rd(0, d, d3);
        chk("rd0_lat1", 32'(d), 32'h11);
        chk("rd0_lat3", 32'(d3), 32'h11);
        push(1, 14'h0002, 8'h00); rd(0, d, d3);
        chk("rd1_lat1", 32'(d), 32'h22);
        chk("rd1_lat3", 32'(d3), 32'h22);

        // Address load (code 1) and auto-increment.
        wr(1, 8'h34); wr(1, 8'h52);
        push(0, 14'h1234, 8'hAA); wr(0, 8'hAA);
        push(0, 14'h1235, 8'hBB); wr(0, 8'hBB);

        // Register writes, including an out-of-range index.
        wr(1, 8'h60); wr(1, 8'h81); exp_regs[15:8] = 8'h60;
        chk("r1_byte", 32'(regs[15:8]), 32'h60);
        wr(1, 8'h11); wr(1, 8'h8F);
        chk("regs_lo", regs[31:0], exp_regs[31:0]);
        chk("regs_hi", regs[87:56], exp_regs[87:56]);

        // Address wrap and CRAM write.
        wr(1, 8'hFF); push(1, 14'h3FFF, 8'h00); wr(1, 8'h3F);
        push(0, 14'h0000, 8'h01); wr(0, 8'h01);
        wr(1, 8'h05); wr(1, 8'hC0);
        push(2, 14'h0005, 8'h3F); wr(0, 8'h3F);

        // Frame interrupt and status clear.
        wr(1, 8'h20); wr(1, 8'h81); exp_regs[15:8] = 8'h20;
        chk("n_int_idle", 32'(n_int), 1);
        frame_int = 1'b1; cyc(1); frame_int = 1'b0; cyc(1);
        chk("n_int_frame", 32'(n_int), 0);
        rd(1, d, d3);
        chk("status_frame", 32'(d), 32'h9F);
        chk("n_int_cleared", 32'(n_int), 1);
        frame_int = 1'b1; cyc(1); frame_int = 1'b0; cyc(1);
        io_rd = 1'b1; port_ctrl = 1'b1;
        cyc(1);
        io_rd = 1'b0; frame_int = 1'b1;
        cyc(1);
        frame_int = 1'b0;
        cyc(3);
        chk("n_int_set_wins", 32'(n_int), 0);
        rd(1, d, d3);
        chk("status_set_wins", 32'(d), 32'h9F);
        chk("n_int_cleared2", 32'(n_int), 1);
        spr_ovf = 1'b1; spr5 = 5'h07; spr_coll = 1'b1; cyc(1); spr_coll = 1'b0; cyc(1);
        rd(1, d, d3);
        chk("status_coll", 32'(d), 32'h67);
        chk("n_int_coll", 32'(n_int), 1);
        spr_ovf = 1'b0;

        // Line counter interrupt.
        wr(1, 8'h00); wr(1, 8'h81); exp_regs[15:8] = 8'h00;
        wr(1, 8'h10); wr(1, 8'h80); exp_regs[7:0] = 8'h10;
        wr(1, 8'h02); wr(1, 8'h8A); exp_regs[87:80] = 8'h02;
        chk("regs_line", regs[31:0], exp_regs[31:0]);
        chk("r10", 32'(regs[87:80]), 32'h02);
        tick(1'b0);
        tick(1'b1);
        chk("line_t1", 32'(n_int), 1);
        tick(1'b1);
        chk("line_t2", 32'(n_int), 1);
        tick(1'b1);
`ifdef LINE_INT_EN
        chk("line_t3", 32'(n_int), 0);
`else
        chk("line_t3_off", 32'(n_int), 1);
`endif
        rd(1, d, d3);
        chk("status_line", 32'(d), 32'h1F);
        chk("n_int_line_clr", 32'(n_int), 1);

        // A control read clears a half-written control word.
        wr(1, 8'h77);
        rd(1, d, d3);
        wr(1, 8'h00); wr(1, 8'h40);
        push(0, 14'h0000, 8'h5A); wr(0, 8'h5A);

        // Asynchronous reset in the middle of a control word.
        wr(1, 8'h99);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_regs", regs[31:0], 0);
        chk("async_rst_n_int", 32'(n_int), 1);
        cyc(2);
        reset = 1'b0;
        cyc(2);
        wr(1, 8'h00); wr(1, 8'h40);
        push(0, 14'h0000, 8'h66); wr(0, 8'h66);

        cyc(5);
        chk("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
